// File: rtl/code_led_if.sv
// code_led_if: code handshake and LED-bank status signals between a code producer and code_led_driver.
interface code_led_if;
  logic [3:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [9:0] led;
  logic       busy;
  logic       err;

  modport master (
    output code_in,
    output code_valid,
    input  code_ready,
    input  led,
    input  busy,
    input  err
  );

  modport slave (
    input  code_in,
    input  code_valid,
    output code_ready,
    output led,
    output busy,
    output err
  );
endinterface

// File: rtl/code_led_driver.sv
// code_led_driver: shows a decimal code on a one-hot LED bank for a hold time, flashes all LEDs on bad codes.
// Build macro CODE_LED_BLINK_EN makes the lit LED blink with half-period BLINK_HALF while a code is shown.
module code_led_driver #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int ERR_CYCLES  = 25_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input logic        clk,
  input logic        rst_n,
  code_led_if.slave  bus
);
  // One down-counter serves both SHOW and ERR since the two states never overlap.
  localparam int CNT_MAX = (HOLD_CYCLES > ERR_CYCLES) ? HOLD_CYCLES : ERR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_LOAD  = CNT_W'(ERR_CYCLES - 1);

  if (ERR_CYCLES < 1) begin : g_err_chk
    $error("code_led_driver: ERR_CYCLES must be >= 1");
  end
  if (BLINK_HALF < 1) begin : g_blink_chk
    $error("code_led_driver: BLINK_HALF must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       led_q;
  logic             busy_q;
  logic             err_q;
  logic             ready_q;
  logic             accept;

`ifdef CODE_LED_BLINK_EN
  localparam int BL_W = $clog2(BLINK_HALF + 1);
  localparam logic [BL_W-1:0] BLINK_LOAD = BL_W'(BLINK_HALF - 1);
  logic [BL_W-1:0] blink_cnt_q;
  logic            blink_on_q;
  logic [9:0]      pat_q;
`endif

  function automatic logic [9:0] decode(input logic [3:0] code);
    decode = 10'b1 << code;
  endfunction

  assign accept         = bus.code_valid & ready_q;
  assign bus.code_ready = ready_q;
  assign bus.led        = led_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
`ifdef CODE_LED_BLINK_EN
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      pat_q       <= '0;
`endif
    end else if (accept && bus.code_in <= 4'd9) begin
      // A new valid code always wins, including on the SHOW timeout clock.
      state_q <= S_SHOW;
      cnt_q   <= HOLD_LOAD;
      led_q   <= decode(bus.code_in);
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
`ifdef CODE_LED_BLINK_EN
      blink_cnt_q <= BLINK_LOAD;
      blink_on_q  <= 1'b1;
      pat_q       <= decode(bus.code_in);
`endif
    end else if (accept) begin
      state_q <= S_ERR;
      cnt_q   <= ERR_LOAD;
      led_q   <= 10'h3FF;
      busy_q  <= 1'b1;
      err_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_SHOW: begin
          if (HOLD_CYCLES != 0 && cnt_q == '0) begin
            state_q <= S_IDLE;
            led_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            if (HOLD_CYCLES != 0) cnt_q <= cnt_q - 1'b1;
`ifdef CODE_LED_BLINK_EN
            if (blink_cnt_q == '0) begin
              blink_cnt_q <= BLINK_LOAD;
              blink_on_q  <= ~blink_on_q;
              led_q       <= blink_on_q ? '0 : pat_q;
            end else begin
              blink_cnt_q <= blink_cnt_q - 1'b1;
            end
`endif
          end
        end
        S_ERR: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            led_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_code_led_driver.sv
// tb_code_led_driver: directed and random checks of code_led_driver against an elapsed-time reference model.
module tb_code_led_driver;
  localparam int HOLD_CYCLES = 8;
  localparam int ERR_CYCLES  = 4;
  localparam int BLINK_HALF  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Reference model: 0 = idle, 1 = showing m_code, 2 = error flash; m_elapsed counts clocks since accept.
  int   m_state;
  int   m_code;
  int   m_elapsed;

  code_led_if bus ();

  code_led_driver #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .ERR_CYCLES (ERR_CYCLES),
    .BLINK_HALF (BLINK_HALF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] model_outs();
    logic [9:0] l;
    logic       lit;
    l   = '0;
`ifdef CODE_LED_BLINK_EN
    lit = ((m_elapsed / BLINK_HALF) % 2) == 0;
`else
    lit = 1'b1;
`endif
    if (m_state == 1 && lit) l = 10'd1 << m_code;
    if (m_state == 2) l = 10'h3FF;
    return {m_state != 2, m_state != 0, m_state == 2, l};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {bus.code_ready, bus.busy, bus.err, bus.led};
  endfunction

  task automatic model_step(input logic v, input int c);
    if (v && m_state != 2) begin
      m_state   = (c <= 9) ? 1 : 2;
      m_code    = c;
      m_elapsed = 0;
    end else if (m_state == 1) begin
      m_elapsed++;
      if (HOLD_CYCLES != 0 && m_elapsed == HOLD_CYCLES) m_state = 0;
    end else if (m_state == 2) begin
      m_elapsed++;
      if (m_elapsed == ERR_CYCLES) m_state = 0;
    end
  endtask

  task automatic tick(input logic v, input logic [3:0] c);
    bus.code_valid = v;
    bus.code_in    = c;
    @(posedge clk);
    model_step(v, int'(c));
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_state != 0; i++) tick(1'b0, 4'd0);
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_code    = 0;
    m_elapsed = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.code_valid = 1'b0;
    bus.code_in    = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_outs() !== 13'b1_0_0_0000000000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", dut_outs(), 13'b1_0_0_0000000000);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_show_timeout();
    tick(1'b1, 4'd3);
    checks++;
    if (bus.led !== 10'b0000001000 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL show3_first led=%b busy=%b exp led=0000001000 busy=1", bus.led, bus.busy);
    end
    for (int k = 1; k <= HOLD_CYCLES; k++) begin
      tick(1'b0, 4'd0);
      checks++;
      if (dut_outs() !== model_outs()) begin
        failures++;
        $display("FAIL show3_hold k=%0d got=%b exp=%b", k, dut_outs(), model_outs());
      end
    end
    checks++;
    if (bus.led !== 10'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL show3_blank led=%b busy=%b exp led=0 busy=0", bus.led, bus.busy);
    end
  endtask

  task automatic test_retrigger();
    tick(1'b1, 4'd9);
    for (int k = 0; k < 4; k++) tick(1'b0, 4'd0);
    tick(1'b1, 4'd0);
    checks++;
    if (bus.led !== 10'b0000000001) begin
      failures++;
      $display("FAIL retrigger_led got=%b exp=0000000001", bus.led);
    end
    for (int k = 1; k <= HOLD_CYCLES; k++) begin
      tick(1'b0, 4'd0);
      checks++;
      if (dut_outs() !== model_outs()) begin
        failures++;
        $display("FAIL retrigger_hold k=%0d got=%b exp=%b", k, dut_outs(), model_outs());
      end
    end
  endtask

  task automatic test_error();
    int err_seen;
    err_seen = 0;
    tick(1'b1, 4'd12);
    checks++;
    if (bus.led !== 10'h3FF || bus.err !== 1'b1 || bus.code_ready !== 1'b0) begin
      failures++;
      $display("FAIL err_enter led=%h err=%b ready=%b exp 3ff/1/0", bus.led, bus.err, bus.code_ready);
    end
    if (bus.err === 1'b1) err_seen++;
    for (int k = 0; k < 12 && !(m_state == 1 && m_code == 5); k++) begin
      tick(1'b1, 4'd5);
      if (bus.err === 1'b1) err_seen++;
      checks++;
      if (dut_outs() !== model_outs()) begin
        failures++;
        $display("FAIL err_hold k=%0d got=%b exp=%b", k, dut_outs(), model_outs());
      end
    end
    checks++;
    if (err_seen != ERR_CYCLES) begin
      failures++;
      $display("FAIL err_length got=%0d exp=%0d", err_seen, ERR_CYCLES);
    end
    checks++;
    if (bus.led !== 10'b0000100000 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL err_then5 led=%b err=%b exp led=0000100000 err=0", bus.led, bus.err);
    end
    bus.code_valid = 1'b0;
    drain();
  endtask

  task automatic test_async_reset();
    tick(1'b1, 4'd7);
    tick(1'b0, 4'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_outs() !== 13'b1_0_0_0000000000) begin
      failures++;
      $display("FAIL async_reset_show got=%b exp=%b", dut_outs(), 13'b1_0_0_0000000000);
    end
    @(negedge clk) rst_n = 1'b1;
    tick(1'b1, 4'd15);
    tick(1'b0, 4'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_outs() !== 13'b1_0_0_0000000000) begin
      failures++;
      $display("FAIL async_reset_err got=%b exp=%b", dut_outs(), 13'b1_0_0_0000000000);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_accept_at_timeout();
    tick(1'b1, 4'd2);
    for (int k = 1; k < HOLD_CYCLES; k++) tick(1'b0, 4'd0);
    checks++;
    if (bus.led !== 10'b0000000100) begin
      failures++;
      $display("FAIL timeout_last_lit got=%b exp=0000000100", bus.led);
    end
    tick(1'b1, 4'd6);
    checks++;
    if (bus.led !== 10'b0001000000 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_accept led=%b busy=%b exp led=0001000000 busy=1", bus.led, bus.busy);
    end
    drain();
  endtask

  task automatic test_blink();
    logic [7:0] pat;
`ifdef CODE_LED_BLINK_EN
    pat = 8'b00110011;
`else
    pat = 8'b11111111;
`endif
    tick(1'b1, 4'd4);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick(1'b0, 4'd0);
      checks++;
      if (bus.led !== (pat[k] ? 10'b0000010000 : 10'd0)) begin
        failures++;
        $display("FAIL blink k=%0d got=%b exp_bit=%b", k, bus.led, pat[k]);
      end
    end
    tick(1'b0, 4'd0);
    checks++;
    if (bus.led !== 10'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL blink_end led=%b busy=%b exp 0/0", bus.led, bus.busy);
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [3:0] c;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      tick(v, c);
      checks++;
      if (dut_outs() !== model_outs()) begin
        failures++;
        $display("FAIL random i=%0d v=%b c=%0d got=%b exp=%b", i, v, c, dut_outs(), model_outs());
      end
    end
    bus.code_valid = 1'b0;
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_show_timeout();
    test_retrigger();
    test_error();
    test_async_reset();
    test_accept_at_timeout();
    test_blink();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "time limit");
  end
endmodule
